// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lamp encodings, FSM state type and BCD helper
package traffic_pkg;

    // One-hot lamp drive values
    localparam logic [2:0] LIGHT_RED = 3'b001;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b100;

    // All segments off (active-low)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    // Binary to 4-digit BCD; callers keep the low 4*DIGITS bits.
    function automatic logic [15:0] to_bcd(input int value);
        logic [15:0] res;
        int          v;
        res = '0;
        v   = value;
        for (int i = 0; i < 4; i++) begin
            res[4*i +: 4] = 4'(v % 10);
            v             = v / 10;
        end
        return res;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - one BCD digit to active-low seven-segment pattern
//   digit : BCD input, values above 9 show blank
//   seg   : {a,b,c,d,e,f,g}, active low
module seven_seg_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/traffic_countdown_ctrl.sv
// rtl/traffic_countdown_ctrl.sv - self-timed RED/GREEN/YELLOW sequencer with BCD countdown display
//   clk, rst   : clock, asynchronous active-high reset
//   en         : run enable, low freezes prescaler, state and count
//   ped_req    : pedestrian request (only when TRAFFIC_PED_EN is defined)
//   light      : one-hot lamp, 001 red / 010 yellow / 100 green
//   count      : BCD seconds remaining, digit 0 in [3:0]
//   seg        : active-low segments per digit, digit 0 in [6:0]
//   phase_done : one-cycle pulse in the cycle a new light first appears
// Optional feature macro: TRAFFIC_PED_EN
module traffic_countdown_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIGITS   = 2,
    parameter int RED_TIME = 30,
    parameter int GRN_TIME = 25,
    parameter int YEL_TIME = 5,
    parameter int PED_MIN  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
`ifdef TRAFFIC_PED_EN
    input  logic                ped_req,
`endif
    output logic [2:0]          light,
    output logic [4*DIGITS-1:0] count,
    output logic [7*DIGITS-1:0] seg,
    output logic                phase_done
);

    localparam int CW       = 4 * DIGITS;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int MAX_TIME = 10 ** DIGITS - 1;

    localparam logic [15:0]   RED_BCD16 = to_bcd(RED_TIME);
    localparam logic [15:0]   GRN_BCD16 = to_bcd(GRN_TIME);
    localparam logic [15:0]   YEL_BCD16 = to_bcd(YEL_TIME);
    localparam logic [CW-1:0] RED_BCD   = RED_BCD16[CW-1:0];
    localparam logic [CW-1:0] GRN_BCD   = GRN_BCD16[CW-1:0];
    localparam logic [CW-1:0] YEL_BCD   = YEL_BCD16[CW-1:0];
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Elaboration-time parameter checks
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 1");
    end
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
        $error("DIGITS must be 1..4");
    end
    if (RED_TIME < 1 || RED_TIME > MAX_TIME) begin : g_bad_red
        $error("RED_TIME out of range for DIGITS");
    end
    if (GRN_TIME < 1 || GRN_TIME > MAX_TIME) begin : g_bad_grn
        $error("GRN_TIME out of range for DIGITS");
    end
    if (YEL_TIME < 1 || YEL_TIME > MAX_TIME) begin : g_bad_yel
        $error("YEL_TIME out of range for DIGITS");
    end

`ifdef TRAFFIC_PED_EN
    localparam logic [15:0]   PED_BCD16 = to_bcd(PED_MIN);
    localparam logic [CW-1:0] PED_BCD   = PED_BCD16[CW-1:0];

    if (PED_MIN < 1 || PED_MIN > GRN_TIME) begin : g_bad_ped_min
        $error("PED_MIN must be 1..GRN_TIME");
    end

    logic ped_q, ped_d;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          phase_done_q, phase_done_d;
    logic          tick;

    // Multi-digit BCD decrement: a zero digit becomes 9 and borrows upward.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick = en && (presc_q == TICK_LAST);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        phase_done_d = 1'b0;
`ifdef TRAFFIC_PED_EN
        // Requests only latch while green; they are dropped in other phases.
        ped_d        = ped_q | (en & ped_req & (state_q == ST_GREEN));
`endif

        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        case (state_q)
            ST_RED: begin
                if (tick) begin
                    if (count_q == COUNT_ONE) begin
                        state_d      = ST_GREEN;
                        count_d      = GRN_BCD;
                        phase_done_d = 1'b1;
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
            ST_GREEN: begin
                if (tick) begin
                    if (count_q == COUNT_ONE) begin
                        state_d      = ST_YELLOW;
                        count_d      = YEL_BCD;
                        phase_done_d = 1'b1;
`ifdef TRAFFIC_PED_EN
                    end else if (ped_q && (count_q > PED_BCD)) begin
                        // BCD order matches numeric order, so a plain compare works.
                        count_d = PED_BCD;
`endif
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
            ST_YELLOW: begin
                if (tick) begin
                    if (count_q == COUNT_ONE) begin
                        state_d      = ST_RED;
                        count_d      = RED_BCD;
                        phase_done_d = 1'b1;
`ifdef TRAFFIC_PED_EN
                        ped_d        = 1'b0;
`endif
                    end else begin
                        count_d = bcd_dec(count_q);
                    end
                end
            end
            default: begin
                // Corrupted state register: fall back to a fresh red phase.
                state_d = ST_RED;
                count_d = RED_BCD;
`ifdef TRAFFIC_PED_EN
                ped_d   = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RED;
            count_q      <= RED_BCD;
            presc_q      <= '0;
            phase_done_q <= 1'b0;
`ifdef TRAFFIC_PED_EN
            ped_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            phase_done_q <= phase_done_d;
`ifdef TRAFFIC_PED_EN
            ped_q        <= ped_d;
`endif
        end
    end

    always_comb begin
        light = LIGHT_RED;
        case (state_q)
            ST_RED:    light = LIGHT_RED;
            ST_GREEN:  light = LIGHT_GRN;
            ST_YELLOW: light = LIGHT_YEL;
            default:   light = LIGHT_RED;
        endcase
    end

    assign count      = count_q;
    assign phase_done = phase_done_q;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        seven_seg_decoder u_dec (
            .digit (count_q[4*gi +: 4]),
            .seg   (seg[7*gi +: 7])
        );
    end

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
// tb/tb_traffic_countdown_ctrl.sv - scoreboard bench for traffic_countdown_ctrl
module tb_traffic_countdown_ctrl;

    localparam int TICK_DIV = 4;
    localparam int RED_T    = 3;
    localparam int GRN_T    = 4;
    localparam int YEL_T    = 2;
    localparam int PED_MIN  = 2;
`ifdef TRAFFIC_PED_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        en2 = 1'b0;
`ifdef TRAFFIC_PED_EN
    logic        ped_req = 1'b0;
`endif
    logic [2:0]  light, light2;
    logic [7:0]  count, count2;
    logic [13:0] seg, seg2;
    logic        phase_done, pd2;

    always #5 clk = ~clk;

    traffic_countdown_ctrl #(
        .TICK_DIV (TICK_DIV), .DIGITS (2), .RED_TIME (RED_T),
        .GRN_TIME (GRN_T), .YEL_TIME (YEL_T), .PED_MIN (PED_MIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
`ifdef TRAFFIC_PED_EN
        .ped_req    (ped_req),
`endif
        .light      (light),
        .count      (count),
        .seg        (seg),
        .phase_done (phase_done)
    );

    traffic_countdown_ctrl #(
        .TICK_DIV (1), .DIGITS (2), .RED_TIME (10),
        .GRN_TIME (4), .YEL_TIME (2), .PED_MIN (2)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
`ifdef TRAFFIC_PED_EN
        .ped_req    (1'b0),
`endif
        .light      (light2),
        .count      (count2),
        .seg        (seg2),
        .phase_done (pd2)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int pd_cnt = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int         stamp;
        logic [2:0] light;
        logic [7:0] count;
        logic       pd;
    } exp_t;

    exp_t q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] exp_seg(input logic [7:0] c);
        return {seg_of(c[7:4]), seg_of(c[3:0])};
    endfunction

    function automatic logic [7:0] to_bcd8(input int n);
        return 8'((n / 10) * 16 + (n % 10));
    endfunction

    // Reference model: phase index (0 red, 1 green, 2 yellow), seconds left,
    // cycles into the current second and the pedestrian request flag.
    int          p, rem, presc;
    bit          ped;
    logic [11:0] m_prev;
    int          ptime [3] = '{RED_T, GRN_T, YEL_T};
    logic [2:0]  lamp  [3] = '{3'b001, 3'b100, 3'b010};

    function automatic void model_step(input bit e, input bit pr);
        bit          tick;
        bit          pd;
        int          np;
        logic [11:0] nt;
        tick = 1'b0;
        pd   = 1'b0;
        if (e) begin
            if (presc == TICK_DIV - 1) begin
                tick  = 1'b1;
                presc = 0;
            end else begin
                presc++;
            end
        end
        np = p;
        if (tick) begin
            if (rem == 1) begin
                np  = (p + 1) % 3;
                rem = ptime[np];
                pd  = 1'b1;
            end else if (PED && ped && p == 1 && rem > PED_MIN) begin
                rem = PED_MIN;
            end else begin
                rem--;
            end
        end
        if (PED && e && pr && p == 1) ped = 1'b1;
        if (np == 0 && p != 0) ped = 1'b0;
        p  = np;
        nt = {lamp[p], to_bcd8(rem), pd};
        if (nt != m_prev) q.push_back('{edge_cnt + 1, lamp[p], to_bcd8(rem), pd});
        m_prev = nt;
    endfunction

    // Monitor: pops the scoreboard whenever an expected change is due, and
    // flags any DUT change the model did not predict.
    logic [11:0] cur, mprev;
    exp_t        e;

    always @(negedge clk) begin
        if (mon_en) begin
            cur = {light, count, phase_done};
            if (phase_done) pd_cnt++;
            while (q.size() > 0 && q[0].stamp < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL sb_stale edge=%0d actual=none required=%0h", q[0].stamp, {q[0].light, q[0].count, q[0].pd});
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].stamp == edge_cnt) begin
                e = q.pop_front();
                chk("sb_light", 32'(light), 32'(e.light));
                chk("sb_count", 32'(count), 32'(e.count));
                chk("sb_phase_done", 32'(phase_done), 32'(e.pd));
                chk("sb_seg", 32'(seg), 32'(exp_seg(e.count)));
            end else if (cur != mprev) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected edge=%0d actual=%0h required=%0h", edge_cnt, cur, mprev);
            end
            mprev = cur;
        end
    end

    task automatic step(input bit ev, input bit pr);
        en = ev;
`ifdef TRAFFIC_PED_EN
        ped_req = pr;
`endif
        model_step(ev, pr);
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; asserts rst mid-cycle.
    task automatic do_reset();
        mon_en = 1'b0;
        en     = 1'b0;
`ifdef TRAFFIC_PED_EN
        ped_req = 1'b0;
`endif
        #3;
        rst = 1'b1;
        #1;
        chk("rst_light", 32'(light), 32'(3'b001));
        chk("rst_count", 32'(count), 32'h03);
        chk("rst_seg", 32'(seg), 32'({7'b0000001, 7'b0000110}));
        chk("rst_phase_done", 32'(phase_done), 32'd0);
        chk("rst2_count", 32'(count2), 32'h10);
        chk("rst2_light", 32'(light2), 32'(3'b001));
        chk("rst2_seg", 32'(seg2), 32'({7'b1001111, 7'b0000001}));
        chk("rst2_phase_done", 32'(pd2), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        p      = 0;
        rem    = RED_T;
        presc  = 0;
        ped    = 1'b0;
        m_prev = {3'b001, 8'h03, 1'b0};
        mprev  = m_prev;
        q.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        int bad;
        @(posedge clk);
        #1;
        do_reset();

        // BCD borrow on the second instance: 10 -> 09, never a hex digit.
        en2 = 1'b1;
        @(posedge clk);
        #1;
        chk("borrow_first_tick", 32'(count2), 32'h09);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        chk("borrow_down_to_one", 32'(count2), 32'h01);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (count2[3:0] > 4'd9 || count2[7:4] > 4'd9) bad++;
            @(posedge clk);
            #1;
        end
        chk("borrow_no_hex_digit", 32'(bad), 32'd0);
        en2 = 1'b0;

        // Full cycle: 12 + 16 + 8 enabled clocks give three phase changes.
        pd_cnt = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        chk("full_cycle_pulses", 32'(pd_cnt), 32'd3);

        // Enable held low mid-red at count 02.
        do_reset();
        for (int i = 0; i < 60 && !(p == 0 && rem == 2 && presc == 1); i++) step(1'b1, 1'b0);
        chk("reach_hold_point", 32'(p == 0 && rem == 2 && presc == 1), 32'd1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        chk("hold_count", 32'(count), 32'h02);
        chk("hold_light", 32'(light), 32'(3'b001));
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

        // Pedestrian request early in green, then at count 1.
        do_reset();
        for (int i = 0; i < 100 && !(p == 1 && rem == 4); i++) step(1'b1, 1'b0);
        chk("reach_green_4", 32'(p == 1 && rem == 4), 32'd1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 40 && !(p == 1 && rem == 1); i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);

        // Randomized enable and request traffic.
        do_reset();
        for (int i = 0; i < 800; i++) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

        // Asynchronous reset mid-green at count 03 (checked inside do_reset).
        for (int i = 0; i < 100 && !(p == 1 && rem == 3); i++) step(1'b1, 1'b0);
        chk("reach_green_3", 32'(p == 1 && rem == 3), 32'd1);
        chk("pre_reset_light", 32'(light), 32'(3'b100));
        do_reset();

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_countdown_ctrl.md
# traffic_countdown_ctrl

Self-timed traffic-light sequencer with a parametrised multi-digit BCD countdown and seven-segment outputs. It drives one-hot lamp outputs through RED → GREEN → YELLOW → RED and shows the seconds remaining in the current phase. It sits between the board clock and the lamp/display pins, and replaces externally supplied select/digit values with an internal state machine, prescaler and down-counter.

## Interface
- TICK_DIV, 100_000_000: clock cycles per countdown tick (one second); ≥1
- DIGITS, 2: number of BCD display digits; 1..4
- RED_TIME, 30: red phase length in ticks; 1..10^DIGITS−1
- GRN_TIME, 25: green phase length in ticks; same range
- YEL_TIME, 5: yellow phase length in ticks; same range
- PED_MIN, 5: green time remaining after a pedestrian request; 1..GRN_TIME (macro builds only)

- clk  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable; low freezes prescaler, state and count
- ped_req  in  1  pedestrian request, level-sampled (present only with TRAFFIC_PED_EN)
- light  out  3  one-hot lamp: 3'b001 red, 3'b010 yellow, 3'b100 green
- count  out  4*DIGITS  BCD seconds remaining; digit 0 in bits [3:0]
- seg  out  7*DIGITS  active-low segments {a,b,c,d,e,f,g} per digit, digit 0 in [6:0]
- phase_done  out  1  one-cycle pulse on each phase change

## Operation
- FSM states: RED, GREEN, YELLOW. Transitions occur only on a tick with count == 1: RED→GREEN, GREEN→YELLOW, YELLOW→RED. On the transition, count is loaded with the new phase's time.
- A tick is generated when en=1 and the prescaler equals TICK_DIV−1. The prescaler then wraps to 0. With TICK_DIV=1, every enabled cycle is a tick.
- On a tick with count > 1, count decrements in BCD. A digit at 0 becomes 9 and borrows from the next digit. The count never reaches 0, so each phase lasts exactly its TIME in ticks.
- Segment encoding: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any non-BCD digit displays blank (1111111).
- light is decoded from the FSM state. Illegal state encodings recover to RED with count = RED_TIME on the next clock.
- Phase times outside their legal range are an elaboration error (generate-time check).

## Timing
- Reset values: light=001, count=BCD(RED_TIME), prescaler=0, phase_done=0, pedestrian latch=0. seg reflects the reset count immediately.
- light, count and phase_done are registered and update on the tick edge. seg is combinational from count, with 0-cycle latency.
- phase_done is high for exactly the one cycle in which the new light value first appears.
- en deasserted mid-phase: all registers hold. On re-enable, the prescaler resumes from its held value with no lost or extra tick.
- rst asserted mid-phase returns all registers to reset values asynchronously. Deassertion must be synchronous to clk externally.

## Configuration
- TRAFFIC_PED_EN defined:
  - ped_req is sampled every enabled cycle into a sticky latch; the latch is only set while in GREEN.
  - On the next tick in GREEN with the latch set and count > PED_MIN, count loads PED_MIN instead of decrementing.
  - If count ≤ PED_MIN, the latch has no effect.
  - The latch clears on entry to RED.
- TRAFFIC_PED_EN undefined: the ped_req port and the latch do not exist, and phase lengths are fixed.

## Structure
- Shared package traffic_pkg:
  - light encodings LIGHT_RED/LIGHT_YEL/LIGHT_GRN
  - FSM state typedef
  - SEG_BLANK constant
  - BCD conversion function for parameter-to-count loading
- Sub-module: the existing seven_seg_decoder, instantiated DIGITS times via generate, with non-BCD inputs handled as blank.

## Test plan
All scenarios use TICK_DIV=4, DIGITS=2, RED=3, GRN=4, YEL=2, PED_MIN=2 unless stated otherwise.
- Reset: rst pulse → light=001, count=8'h03, seg={0000001,0000110}, phase_done=0.
- Full cycle, en=1: red for 12 clocks (count 3,2,1), then green for 16, yellow for 8, then red again; exactly 3 phase_done pulses, each aligned with the light change.
- BCD borrow, RED_TIME=10: count 8'h10 → 8'h09 on the first tick, and never shows 8'h0F.
- en low for 20 cycles at count=8'h02 mid-red: count and light hold; the next tick arrives after the remaining prescaler cycles only.
- TRAFFIC_PED_EN with GRN_TIME=9: one-cycle ped_req at count=8'h07 → next tick count=8'h02, then yellow 2 ticks later. ped_req at count=8'h01 → no change.
- Async rst asserted mid-green at count=8'h03 → light=001 and count=8'h03 (RED_TIME) before the next clock edge.
